// File: rtl/rsu_pkg.sv
// Shared definitions for the remote-update parameter writer.
// Contents: remote-update parameter codes, controller state encoding, the phase
// encoding used between the controller and its handshake engine, and a helper
// that sizes the timeout counter.
package rsu_pkg;

  localparam int unsigned RU_PARAM_W = 3;
  localparam int unsigned RU_DATA_W  = 24;

  localparam logic [RU_PARAM_W-1:0] PARAM_WDOG_EN   = 3'b011;
  localparam logic [RU_PARAM_W-1:0] PARAM_BOOT_ADDR = 3'b100;

  typedef enum logic [3:0] {
    StIdle,
    StWrWdog,
    StWaitHi1,
    StWaitLo1,
    StWrAddr,
    StWaitHi2,
    StWaitLo2,
    StReconf,
    StErr
  } rsu_state_e;

  // Handshake phase requested from rsu_write_txn by the controller.
  typedef enum logic [1:0] {
    PhIdle,
    PhStrobe,
    PhWaitHi,
    PhWaitLo
  } txn_phase_e;

  // Bits needed to count 0..max_val inclusive; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rsu_param_writer_if.sv
// Bundle of the upstream request/status signals and the remote-update core
// signals of rsu_param_writer.
//   slave  : the writer's view (takes requests and core busy, drives status/core)
//   master : the environment's view (upstream sequencer plus remote-update core)
// Signals: write, reconfig, image_addr -> writer; busy, error -> upstream;
//          ru_param, ru_data_in, ru_write_param, ru_reconfig -> core;
//          ru_busy -> writer.
interface rsu_param_writer_if #(
  parameter int unsigned ADDR_W = 22
) ();
  import rsu_pkg::*;

  logic                  write;
  logic                  reconfig;
  logic [ADDR_W-1:0]     image_addr;
  logic                  busy;
  logic                  error;
  logic [RU_PARAM_W-1:0] ru_param;
  logic [RU_DATA_W-1:0]  ru_data_in;
  logic                  ru_write_param;
  logic                  ru_reconfig;
  logic                  ru_busy;

  modport slave (
    input  write, reconfig, image_addr, ru_busy,
    output busy, error, ru_param, ru_data_in, ru_write_param, ru_reconfig
  );

  modport master (
    output write, reconfig, image_addr, ru_busy,
    input  busy, error, ru_param, ru_data_in, ru_write_param, ru_reconfig
  );

endinterface

// File: rtl/rsu_write_txn.sv
// Single parameter-write handshake engine toward the remote-update core:
// one-cycle write strobe, wait for ru_busy to rise (bounded by TMO_CYC), then
// wait for it to fall (unbounded). The controller selects the phase; this block
// produces the strobe and reports the handshake events.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_phase          requested handshake phase
//   i_ru_busy        core busy flag
//   o_write_param    write strobe to the core
//   o_hi_seen        ru_busy observed high during the wait-high phase
//   o_lo_seen        ru_busy observed low during the wait-low phase
//   o_timeout        wait-high phase ran out of cycles
module rsu_write_txn
  import rsu_pkg::*;
#(
  parameter int unsigned TMO_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  txn_phase_e i_phase,
  input  logic       i_ru_busy,
  output logic       o_write_param,
  output logic       o_hi_seen,
  output logic       o_lo_seen,
  output logic       o_timeout
);

  localparam int unsigned CntW = cnt_width(TMO_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(TMO_CYC);

  logic [CntW-1:0] r_cnt;

  // Held at zero outside the wait-high phase, so every wait-high starts from 0.
  // Saturates at CntMax instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_phase != PhWaitHi) begin
      r_cnt <= '0;
    end else if (r_cnt != CntMax) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    o_write_param = (i_phase == PhStrobe);
    o_hi_seen     = (i_phase == PhWaitHi) && i_ru_busy;
    o_lo_seen     = (i_phase == PhWaitLo) && !i_ru_busy;
    // The first wait-high cycle sees count 0, so timeout fires on the
    // (TMO_CYC+1)-th cycle without ru_busy.
    o_timeout     = (i_phase == PhWaitHi) && !i_ru_busy && (r_cnt == CntMax);
  end

endmodule

// File: rtl/rsu_param_writer.sv
// Remote-update parameter writer. On a write request it programs the core's
// watchdog-enable parameter (data 0) and then the boot-address parameter
// (latched image_addr), each through the shared rsu_write_txn handshake. A
// reconfig request from idle asserts ru_reconfig until reset. A handshake
// timeout parks the block in a sticky error state until reset.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        rsu_param_writer_if slave: write, reconfig, image_addr, busy,
//              error, ru_param, ru_data_in, ru_write_param, ru_reconfig, ru_busy
module rsu_param_writer
  import rsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  rsu_param_writer_if.slave   bus
);

  rsu_state_e            r_state;
  rsu_state_e            w_state_d;
  txn_phase_e            w_phase;
  logic [ADDR_W-1:0]     r_addr;
  logic [RU_PARAM_W-1:0] r_ru_param;
  logic [RU_DATA_W-1:0]  r_ru_data;
  logic [RU_DATA_W-1:0]  w_addr_ext;
  logic                  w_accept;
  logic                  w_write_param;
  logic                  w_hi_seen;
  logic                  w_lo_seen;
  logic                  w_timeout;

  assign w_accept = (r_state == StIdle) && bus.write;

  always_comb begin
    w_addr_ext               = '0;
    w_addr_ext[ADDR_W-1:0]   = r_addr;
  end

  // Phase decode kept apart from next-state logic: the engine's event outputs
  // depend on the phase and feed back into the next-state decision.
  always_comb begin
    w_phase = PhIdle;
    unique case (r_state)
      StWrWdog,  StWrAddr:  w_phase = PhStrobe;
      StWaitHi1, StWaitHi2: w_phase = PhWaitHi;
      StWaitLo1, StWaitLo2: w_phase = PhWaitLo;
      default:              w_phase = PhIdle;
    endcase
  end

  rsu_write_txn #(
    .TMO_CYC (TMO_CYC)
  ) u_txn (
    .clk           (clk),
    .rst           (rst),
    .i_phase       (w_phase),
    .i_ru_busy     (bus.ru_busy),
    .o_write_param (w_write_param),
    .o_hi_seen     (w_hi_seen),
    .o_lo_seen     (w_lo_seen),
    .o_timeout     (w_timeout)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      // write has priority over reconfig; error is never set while idle.
      StIdle: begin
        if (bus.write)         w_state_d = StWrWdog;
        else if (bus.reconfig) w_state_d = StReconf;
      end
      StWrWdog:  w_state_d = StWaitHi1;
      StWaitHi1: begin
        if (w_hi_seen)      w_state_d = StWaitLo1;
        else if (w_timeout) w_state_d = StErr;
      end
      StWaitLo1: if (w_lo_seen) w_state_d = StWrAddr;
      StWrAddr:  w_state_d = StWaitHi2;
      StWaitHi2: begin
        if (w_hi_seen)      w_state_d = StWaitLo2;
        else if (w_timeout) w_state_d = StErr;
      end
      StWaitLo2: if (w_lo_seen) w_state_d = StIdle;
      StReconf:  w_state_d = StReconf;
      StErr:     w_state_d = StErr;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Parameter select/data are loaded on entry to each strobe state and then
  // held through the following waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_ru_param <= '0;
      r_ru_data  <= '0;
    end else if (w_accept) begin
      r_addr     <= bus.image_addr;
      r_ru_param <= PARAM_WDOG_EN;
      r_ru_data  <= '0;
    end else if ((r_state == StWaitLo1) && w_lo_seen) begin
      r_ru_param <= PARAM_BOOT_ADDR;
      r_ru_data  <= w_addr_ext;
    end
  end

  assign bus.ru_param       = r_ru_param;
  assign bus.ru_data_in     = r_ru_data;
  assign bus.ru_write_param = w_write_param;
  assign bus.ru_reconfig    = (r_state == StReconf);
  assign bus.error          = (r_state == StErr);
  assign bus.busy           = (r_state != StIdle) || bus.ru_busy;

endmodule

// File: tb/tb_rsu_param_writer.sv
module tb_rsu_param_writer;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned TMO_CYC = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   strobe_cnt = 0;

  rsu_param_writer_if #(.ADDR_W(ADDR_W)) dut_if ();

  rsu_param_writer #(
    .ADDR_W  (ADDR_W),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut_if.ru_write_param === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Core model, called in the strobe cycle S: ru_busy high in cycles S+3..S+12,
  // returns in cycle S+13 with ru_busy just lowered.
  task automatic core_handshake();
    step(); step(); step();
    dut_if.ru_busy = 1'b1;
    repeat (10) step();
    dut_if.ru_busy = 1'b0;
  endtask

  task automatic test_reset();
    dut_if.write = 1'b0; dut_if.reconfig = 1'b0;
    dut_if.image_addr = '0; dut_if.ru_busy = 1'b0;
    rst = 1'b1;
    step(); step();
    if (dut_if.busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", dut_if.busy); n_fail++; end
    n_cmp++;
    if (dut_if.error !== 1'b0) begin $display("FAIL rst_error: got %b want 0", dut_if.error); n_fail++; end
    n_cmp++;
    if (dut_if.ru_write_param !== 1'b0) begin $display("FAIL rst_wp: got %b want 0", dut_if.ru_write_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_reconfig !== 1'b0) begin $display("FAIL rst_reconfig: got %b want 0", dut_if.ru_reconfig); n_fail++; end
    n_cmp++;
    if (dut_if.ru_param !== 3'd0) begin $display("FAIL rst_param: got %0h want 0", dut_if.ru_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_data_in !== 24'd0) begin $display("FAIL rst_data: got %0h want 0", dut_if.ru_data_in); n_fail++; end
    n_cmp++;
    dut_if.ru_busy = 1'b1; #1;
    if (dut_if.busy !== 1'b1) begin $display("FAIL rst_busy_follow: got %b want 1", dut_if.busy); n_fail++; end
    n_cmp++;
    dut_if.ru_busy = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_seq();
    int n0;
    n0 = strobe_cnt;
    dut_if.image_addr = 22'h05A000; dut_if.write = 1'b1;
    step();
    dut_if.write = 1'b0;
    if (dut_if.ru_write_param !== 1'b1) begin $display("FAIL wr1_strobe: got %b want 1", dut_if.ru_write_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_param !== 3'b011) begin $display("FAIL wr1_param: got %0h want 3", dut_if.ru_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_data_in !== 24'd0) begin $display("FAIL wr1_data: got %0h want 0", dut_if.ru_data_in); n_fail++; end
    n_cmp++;
    if (dut_if.busy !== 1'b1) begin $display("FAIL wr1_busy: got %b want 1", dut_if.busy); n_fail++; end
    n_cmp++;
    core_handshake();
    if (dut_if.ru_write_param !== 1'b0) begin $display("FAIL wr_lo1_nostrobe: got %b want 0", dut_if.ru_write_param); n_fail++; end
    n_cmp++;
    step();
    if (dut_if.ru_write_param !== 1'b1) begin $display("FAIL wr2_strobe: got %b want 1", dut_if.ru_write_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_param !== 3'b100) begin $display("FAIL wr2_param: got %0h want 4", dut_if.ru_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_data_in !== 24'h05A000) begin $display("FAIL wr2_data: got %0h want 05a000", dut_if.ru_data_in); n_fail++; end
    n_cmp++;
    core_handshake();
    if (dut_if.busy !== 1'b1) begin $display("FAIL wr_lo2_busy: got %b want 1", dut_if.busy); n_fail++; end
    n_cmp++;
    step();
    if (dut_if.busy !== 1'b0) begin $display("FAIL wr_done_busy: got %b want 0", dut_if.busy); n_fail++; end
    n_cmp++;
    if ((strobe_cnt - n0) !== 2) begin $display("FAIL wr_strobes: got %0d want 2", strobe_cnt - n0); n_fail++; end
    n_cmp++;
    if (dut_if.ru_reconfig !== 1'b0) begin $display("FAIL wr_reconfig: got %b want 0", dut_if.ru_reconfig); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_write_and_reconfig();
    dut_if.image_addr = 22'h001234; dut_if.write = 1'b1; dut_if.reconfig = 1'b1;
    step();
    dut_if.write = 1'b0; dut_if.reconfig = 1'b0;
    if (dut_if.ru_write_param !== 1'b1) begin $display("FAIL both_strobe: got %b want 1", dut_if.ru_write_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_reconfig !== 1'b0) begin $display("FAIL both_reconfig0: got %b want 0", dut_if.ru_reconfig); n_fail++; end
    n_cmp++;
    core_handshake();
    step();
    if (dut_if.ru_data_in !== 24'h001234) begin $display("FAIL both_data: got %0h want 001234", dut_if.ru_data_in); n_fail++; end
    n_cmp++;
    core_handshake();
    step(); step();
    if (dut_if.ru_reconfig !== 1'b0) begin $display("FAIL both_reconfig1: got %b want 0", dut_if.ru_reconfig); n_fail++; end
    n_cmp++;
    if (dut_if.busy !== 1'b0) begin $display("FAIL both_busy: got %b want 0", dut_if.busy); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_second_write();
    int n0;
    n0 = strobe_cnt;
    dut_if.image_addr = 22'h2ABCDE; dut_if.write = 1'b1;
    step();
    dut_if.write = 1'b0;
    step();
    dut_if.image_addr = 22'h111111; dut_if.write = 1'b1;
    step();
    dut_if.write = 1'b0;
    step();
    dut_if.ru_busy = 1'b1;
    repeat (10) step();
    dut_if.ru_busy = 1'b0;
    step();
    if (dut_if.ru_data_in !== 24'h2ABCDE) begin $display("FAIL w2_data: got %0h want 2abcde", dut_if.ru_data_in); n_fail++; end
    n_cmp++;
    core_handshake();
    step();
    if ((strobe_cnt - n0) !== 2) begin $display("FAIL w2_strobes: got %0d want 2", strobe_cnt - n0); n_fail++; end
    n_cmp++;
    if (dut_if.busy !== 1'b0) begin $display("FAIL w2_busy: got %b want 0", dut_if.busy); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    dut_if.image_addr = 22'h000001; dut_if.write = 1'b1;
    step();
    dut_if.write = 1'b0;
    core_handshake();
    step(); step(); step(); step();
    dut_if.ru_busy = 1'b1;
    step();
    rst = 1'b1;
    step();
    if (dut_if.busy !== 1'b1) begin $display("FAIL rm_busy_hi: got %b want 1", dut_if.busy); n_fail++; end
    n_cmp++;
    if (dut_if.ru_write_param !== 1'b0) begin $display("FAIL rm_wp: got %b want 0", dut_if.ru_write_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_param !== 3'd0) begin $display("FAIL rm_param: got %0h want 0", dut_if.ru_param); n_fail++; end
    n_cmp++;
    if (dut_if.ru_data_in !== 24'd0) begin $display("FAIL rm_data: got %0h want 0", dut_if.ru_data_in); n_fail++; end
    n_cmp++;
    dut_if.ru_busy = 1'b0; #1;
    if (dut_if.busy !== 1'b0) begin $display("FAIL rm_busy_lo: got %b want 0", dut_if.busy); n_fail++; end
    n_cmp++;
    rst = 1'b0;
    dut_if.image_addr = 22'h3FFFFF; dut_if.write = 1'b1;
    step();
    dut_if.write = 1'b0;
    if (dut_if.ru_param !== 3'b011) begin $display("FAIL rm_new_param: got %0h want 3", dut_if.ru_param); n_fail++; end
    n_cmp++;
    core_handshake();
    step();
    if (dut_if.ru_data_in !== 24'h3FFFFF) begin $display("FAIL rm_new_data: got %0h want 3fffff", dut_if.ru_data_in); n_fail++; end
    n_cmp++;
    core_handshake();
    step();
    if (dut_if.busy !== 1'b0) begin $display("FAIL rm_done_busy: got %b want 0", dut_if.busy); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_reconfig();
    int n0;
    n0 = strobe_cnt;
    dut_if.reconfig = 1'b1;
    step();
    dut_if.reconfig = 1'b0;
    if (dut_if.ru_reconfig !== 1'b1) begin $display("FAIL rc_first: got %b want 1", dut_if.ru_reconfig); n_fail++; end
    n_cmp++;
    if (dut_if.busy !== 1'b1) begin $display("FAIL rc_busy: got %b want 1", dut_if.busy); n_fail++; end
    n_cmp++;
    dut_if.write = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      dut_if.write = 1'b0;
      if (dut_if.ru_reconfig !== 1'b1) begin
        $display("FAIL rc_hold[%0d]: got %b want 1", i, dut_if.ru_reconfig); n_fail++;
      end
      n_cmp++;
    end
    if ((strobe_cnt - n0) !== 0) begin $display("FAIL rc_strobes: got %0d want 0", strobe_cnt - n0); n_fail++; end
    n_cmp++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (dut_if.ru_reconfig !== 1'b0) begin $display("FAIL rc_rst: got %b want 0", dut_if.ru_reconfig); n_fail++; end
    n_cmp++;
    step();
  endtask

  task automatic test_timeout();
    int n0;
    n0 = strobe_cnt;
    dut_if.image_addr = 22'h000ABC; dut_if.write = 1'b1;
    step();
    dut_if.write = 1'b0;
    step();
    repeat (TMO_CYC) step();
    if (dut_if.error !== 1'b0) begin $display("FAIL to_early: got %b want 0", dut_if.error); n_fail++; end
    n_cmp++;
    step();
    if (dut_if.error !== 1'b1) begin $display("FAIL to_error: got %b want 1", dut_if.error); n_fail++; end
    n_cmp++;
    if (dut_if.busy !== 1'b1) begin $display("FAIL to_busy: got %b want 1", dut_if.busy); n_fail++; end
    n_cmp++;
    dut_if.write = 1'b1; dut_if.reconfig = 1'b1;
    repeat (5) step();
    dut_if.write = 1'b0; dut_if.reconfig = 1'b0;
    if (dut_if.error !== 1'b1) begin $display("FAIL to_sticky: got %b want 1", dut_if.error); n_fail++; end
    n_cmp++;
    if (dut_if.ru_reconfig !== 1'b0) begin $display("FAIL to_reconfig: got %b want 0", dut_if.ru_reconfig); n_fail++; end
    n_cmp++;
    if ((strobe_cnt - n0) !== 1) begin $display("FAIL to_strobes: got %0d want 1", strobe_cnt - n0); n_fail++; end
    n_cmp++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (dut_if.error !== 1'b0) begin $display("FAIL to_rst_error: got %b want 0", dut_if.error); n_fail++; end
    n_cmp++;
    if (dut_if.busy !== 1'b0) begin $display("FAIL to_rst_busy: got %b want 0", dut_if.busy); n_fail++; end
    n_cmp++;
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_write_and_reconfig();
    test_second_write();
    test_reset_mid();
    test_reconfig();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
